io_interrupt_ctrl: RTL

//  Sequences the I/O and interrupt path next to the main Controller.
//  - Owns INPR/OUTR, FGI/FGO, IEN and the R (interrupt-cycle) flip-flop.
//  - Runs the valid/ready handshake with one input and one output character device.
//  - Tells the control-signal generator when to enter the interrupt cycle, and flags RT0/RT1/RT2.
//  - The timer (state counter) stays external; this block only observes `state`.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/io_interrupt_ctrl_if.sv | 27 ++
 rtl/io_flag_port.sv | 59 +++++
 rtl/io_interrupt_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared constants for the basic-computer control path: timer T-state
// encodings, IR bit positions of the I/O instructions, default widths, and a
// small helper used by the interrupt logic.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // Default widths of the character data path and of the timer state.
    localparam int DATA_W  = 8;
    localparam int STATE_W = 4;

    // Timer T-states that matter to the I/O / interrupt path.
    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;

    // IR bit positions that select each register-I/O instruction (IR[11:6]).
    localparam int IO_BIT_INP = 11;
    localparam int IO_BIT_OUT = 10;
    localparam int IO_BIT_SKI = 9;
    localparam int IO_BIT_SKO = 8;
    localparam int IO_BIT_ION = 7;
    localparam int IO_BIT_IOF = 6;

    // True once the timer is past the T0..T2 window that an interrupt cycle
    // would occupy; R may only be raised from T3 onwards.
    function automatic logic after_t2(input logic [31:0] state);
        return state > 32'(T2);
    endfunction

endpackage : ctrl_pkg

// File: rtl/io_interrupt_ctrl_if.sv
// ---------------------------------------------------------------------------
// io_interrupt_ctrl_if
// Valid/ready bundle between the I/O controller and its two character
// devices (one input, one output).
//   master : device side  - drives in_valid/in_data and out_ready
//   slave  : controller   - drives in_ready, out_valid/out_data
// ---------------------------------------------------------------------------
interface io_interrupt_ctrl_if #(
    parameter int DATA_W = ctrl_pkg::DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface : io_interrupt_ctrl_if

// File: rtl/io_flag_port.sv
// ---------------------------------------------------------------------------
// io_flag_port
// One data register plus its ready flag. Used for both directions:
//   input  (INPR/FGI): device handshake loads data and sets the flag,
//                      INP clears the flag and leaves the data alone.
//   output (OUTR/FGO): OUT loads data from AC and clears the flag,
//                      device handshake sets the flag.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   set_flag_i    flag <= 1
//   clr_flag_i    flag <= 0 (wins over set)
//   load_i        data <= load_data_i
//   load_data_i   value to load
//   data_o        data register
//   flag_o        flag register
// ---------------------------------------------------------------------------
module io_flag_port #(
    parameter int   DATA_W   = ctrl_pkg::DATA_W,
    parameter logic FLAG_RST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_flag_i,
    input  logic              clr_flag_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              flag_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              flag_q, flag_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the ifs below can leave a value unassigned and infer a latch.
        data_d = data_q;
        flag_d = flag_q;
        if (load_i)     data_d = load_data_i;
        if (set_flag_i) flag_d = 1'b1;
        // The owning logic gates set and clear on opposite flag values, so
        // they never overlap; clear is given priority regardless.
        if (clr_flag_i) flag_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            flag_q <= FLAG_RST;
        end else begin
            data_q <= data_d;
            flag_q <= flag_d;
        end
    end

    assign data_o = data_q;
    assign flag_o = flag_q;
endmodule : io_flag_port

// File: rtl/io_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// io_interrupt_ctrl
// I/O and interrupt sequencing beside the main controller. Owns INPR/OUTR,
// FGI/FGO, IEN and the R flip-flop; runs the device handshakes; reports the
// interrupt-cycle steps RT0..RT2 decoded from the external timer state.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   state               timer T-state (observed only)
//   inp/out/ski/sko/ion/iof_exec   decoded I/O instructions, T3 only
//   ac_low              AC low byte, loaded into OUTR by OUT
//   dev_bus (slave)     in_valid/in_data/in_ready, out_valid/out_data/out_ready
//   inpr                INPR contents
//   fgi, fgo, ien       flag registers
//   r_flag              R flip-flop (interrupt cycle pending / active)
//   skip_req            comb: SKI with FGI set or SKO with FGO set
//   irq_step            comb one-hot {RT2,RT1,RT0}
//   io_err              one-cycle pulse after INP with FGI=0 or OUT with FGO=0
// ---------------------------------------------------------------------------
module io_interrupt_ctrl #(
    parameter int DATA_W     = ctrl_pkg::DATA_W,
    parameter int STATE_W    = ctrl_pkg::STATE_W,
    parameter bit IRQ_ON_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state,
    input  logic               inp_exec,
    input  logic               out_exec,
    input  logic               ski_exec,
    input  logic               sko_exec,
    input  logic               ion_exec,
    input  logic               iof_exec,
    input  logic [DATA_W-1:0]  ac_low,
    io_interrupt_ctrl_if.slave dev_bus,
    output logic [DATA_W-1:0]  inpr,
    output logic               fgi,
    output logic               fgo,
    output logic               ien,
    output logic               r_flag,
    output logic               skip_req,
    output logic [2:0]         irq_step,
    output logic               io_err
);
    logic [DATA_W-1:0] outr;
    logic in_fire, out_fire, inp_ok, out_ok;
    logic at_t0, at_t1, at_t2, rt2, irq_req, r_set;
    logic ien_q, ien_d, r_q, r_d, io_err_q, io_err_d;

    assign at_t0 = (state == STATE_W'(ctrl_pkg::T0));
    assign at_t1 = (state == STATE_W'(ctrl_pkg::T1));
    assign at_t2 = (state == STATE_W'(ctrl_pkg::T2));

    // Device-side handshake: a flag that is set blocks the input device, and
    // a cleared output flag means OUTR still holds an unconsumed character.
    assign dev_bus.in_ready  = ~fgi;
    assign dev_bus.out_valid = ~fgo;
    assign dev_bus.out_data  = outr;

    assign in_fire  = dev_bus.in_valid  & ~fgi;
    assign out_fire = dev_bus.out_ready & ~fgo;
    assign inp_ok   = inp_exec & fgi;
    assign out_ok   = out_exec & fgo;

    io_flag_port #(
        .DATA_W   (DATA_W),
        .FLAG_RST (1'b0)
    ) u_in_port (
        .clk         (clk),
        .rst         (rst),
        .set_flag_i  (in_fire),
        .clr_flag_i  (inp_ok),
        .load_i      (in_fire),
        .load_data_i (dev_bus.in_data),
        .data_o      (inpr),
        .flag_o      (fgi)
    );

    // Output flag comes out of reset set: the device has nothing pending.
    io_flag_port #(
        .DATA_W   (DATA_W),
        .FLAG_RST (1'b1)
    ) u_out_port (
        .clk         (clk),
        .rst         (rst),
        .set_flag_i  (out_fire),
        .clr_flag_i  (out_ok),
        .load_i      (out_ok),
        .load_data_i (ac_low),
        .data_o      (outr),
        .flag_o      (fgo)
    );

    assign irq_req = fgi | (IRQ_ON_OUT & fgo);
    assign rt2     = r_q & at_t2;
    // A request seen during T0..T2 is held off until T3 so it never lands
    // in the middle of a fetch.
    assign r_set   = ~r_q & ien_q & irq_req & ctrl_pkg::after_t2(32'(state));

    always_comb begin
        ien_d    = ien_q;
        r_d      = r_q;
        io_err_d = (inp_exec & ~fgi) | (out_exec & ~fgo);

        if (ion_exec) ien_d = 1'b1;
        if (iof_exec) ien_d = 1'b0;

        // RT2 ends the interrupt cycle; clearing IEN with it also stops R
        // from being raised again straight away.
        if (rt2) begin
            ien_d = 1'b0;
            r_d   = 1'b0;
        end else if (r_set) begin
            r_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien_q    <= 1'b0;
            r_q      <= 1'b0;
            io_err_q <= 1'b0;
        end else begin
            ien_q    <= ien_d;
            r_q      <= r_d;
            io_err_q <= io_err_d;
        end
    end

    assign ien      = ien_q;
    assign r_flag   = r_q;
    assign io_err   = io_err_q;
    assign skip_req = (ski_exec & fgi) | (sko_exec & fgo);
    assign irq_step = r_q ? {at_t2, at_t1, at_t0} : 3'b000;

endmodule : io_interrupt_ctrl
